pck_inj_arbiter: RTL

- Round-robin scheduler that shares one packet injector endpoint among N local traffic sources (trace players, synthetic generators).
- Sits between the sources and the injector's control interface.
- Picks one eligible packet request per cycle, drives the injector's pck_wr/vc/size/endp_addr, returns a one-cycle ack to the winner, then enforces a programmable inter-packet gap.

---
 rtl/pck_inj_arbiter_pkg.sv | 21 ++
 rtl/pck_inj_arbiter_if.sv | 35 +++
 rtl/pck_inj_rr_pick.sv | 32 +++
 rtl/pck_inj_arbiter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/pck_inj_arbiter_pkg.sv
// Shared types and helpers for the packet-injector round-robin arbiter.
// Optional statistics are enabled with PCK_INJ_ARB_STAT_EN.
package pck_inj_arbiter_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StGap
  } arb_state_e;

  localparam int unsigned StatGrantW = 32;
  localparam int unsigned StatWaitW  = 16;

  typedef logic [StatGrantW-1:0] stat_grant_t;
  typedef logic [StatWaitW-1:0]  stat_wait_t;

  // Index width for n entries; a single entry still needs one bit.
  function automatic int unsigned log2w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pck_inj_arbiter_if.sv
// Source-request and injector-control bundle shared by the arbiter and its environment.
// master: sources plus injector side; slave: the arbiter.
interface pck_inj_arbiter_if
  import pck_inj_arbiter_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned V        = 4,
  parameter int unsigned PCK_SIZw = 8,
  parameter int unsigned EAw      = 8
);
  localparam int unsigned SrcW = log2w(N);

  logic [N-1:0]          req;
  logic [N*V-1:0]        req_vc;
  logic [N*PCK_SIZw-1:0] req_size;
  logic [N*EAw-1:0]      req_dst;
  logic [N-1:0]          ack;
  logic [V-1:0]          inj_ready;
  logic                  inj_pck_wr;
  logic [V-1:0]          inj_vc;
  logic [PCK_SIZw-1:0]   inj_size;
  logic [EAw-1:0]        inj_dst;
  logic [SrcW-1:0]       inj_src;

  modport master (
    output req, req_vc, req_size, req_dst, inj_ready,
    input  ack, inj_pck_wr, inj_vc, inj_size, inj_dst, inj_src
  );

  modport slave (
    input  req, req_vc, req_size, req_dst, inj_ready,
    output ack, inj_pck_wr, inj_vc, inj_size, inj_dst, inj_src
  );

endinterface

// File: rtl/pck_inj_rr_pick.sv
// Combinational rotate-priority picker: first set bit of elig scanning ptr+1, ptr+2, ... mod N.
module pck_inj_rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [N-1:0]    elig,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] idx,
  output logic            any
);

  always_comb begin
    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    grant    = '0;
    idx      = '0;
    any      = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand     = (32'(ptr) + k) % N;
      cand_idx = IdxW'(cand);
      if (!any && elig[cand_idx]) begin
        any             = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/pck_inj_arbiter.sv
// Round-robin scheduler sharing one packet injector among N sources, with a programmable
// post-issue gap. Define PCK_INJ_ARB_STAT_EN to add per-source grant/wait statistics.
module pck_inj_arbiter
  import pck_inj_arbiter_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned V        = 4,
  parameter int unsigned PCK_SIZw = 8,
  parameter int unsigned EAw      = 8,
  parameter int unsigned MIN_SIZE = 2,
  parameter int unsigned GAPw     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [GAPw-1:0]         gap_cfg,
  pck_inj_arbiter_if.slave        bus,
  output logic                    err
`ifdef PCK_INJ_ARB_STAT_EN
  ,
  output logic [N*StatGrantW-1:0] stat_grant,
  output logic [N*StatWaitW-1:0]  stat_max_wait
`endif
);

  localparam int unsigned SrcW = log2w(N);

  arb_state_e      state_q, state_d;
  logic [SrcW-1:0] ptr_q, ptr_d;
  logic [GAPw-1:0] gap_cnt_q, gap_cnt_d;
  logic            err_q;

  logic [N-1:0]    elig, malformed, win_grant;
  logic [SrcW-1:0] win_idx;
  logic            any_elig, issue;

  for (genvar i = 0; i < N; i++) begin : g_src
    logic [V-1:0]        vc;
    logic [PCK_SIZw-1:0] sz;
    logic                vc_ok, sz_ok;
    assign vc           = bus.req_vc[i*V +: V];
    assign sz           = bus.req_size[i*PCK_SIZw +: PCK_SIZw];
    assign vc_ok        = (vc != '0) && ((vc & (vc - V'(1))) == '0);
    assign sz_ok        = sz >= PCK_SIZw'(MIN_SIZE);
    assign elig[i]      = bus.req[i] && vc_ok && sz_ok && ((vc & bus.inj_ready) != '0);
    assign malformed[i] = bus.req[i] && !(vc_ok && sz_ok);
  end

  pck_inj_rr_pick #(
    .N    (N),
    .IdxW (SrcW)
  ) u_pick (
    .elig  (elig),
    .ptr   (ptr_q),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (any_elig)
  );

  // Gated by reset so every output is 0 while reset is held, even with requests pending.
  assign issue = reset && (state_q == StIdle) && any_elig;
  assign err   = err_q;

  always_comb begin
    bus.ack        = '0;
    bus.inj_pck_wr = issue;
    bus.inj_vc     = '0;
    bus.inj_size   = '0;
    bus.inj_dst    = '0;
    bus.inj_src    = issue ? win_idx : '0;
    for (int i = 0; i < N; i++) begin
      if (issue && win_grant[i]) begin
        bus.ack[i]   = 1'b1;
        bus.inj_vc   = bus.req_vc[i*V +: V];
        bus.inj_size = bus.req_size[i*PCK_SIZw +: PCK_SIZw];
        bus.inj_dst  = bus.req_dst[i*EAw +: EAw];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          ptr_d = win_idx;
          // gap_cfg is only looked at here, so changes during a gap wait for the next issue.
          if (gap_cfg != '0) begin
            gap_cnt_d = gap_cfg;
            state_d   = StGap;
          end
        end
      end
      StGap: begin
        gap_cnt_d = gap_cnt_q - GAPw'(1);
        if (gap_cnt_q <= GAPw'(1)) begin
          gap_cnt_d = '0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      ptr_q     <= SrcW'(N - 1);
      gap_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gap_cnt_q <= gap_cnt_d;
      err_q     <= err_q | (|malformed);
    end
  end

`ifdef PCK_INJ_ARB_STAT_EN
  for (genvar i = 0; i < N; i++) begin : g_stat
    stat_grant_t grant_q;
    stat_wait_t  wait_q, max_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        grant_q <= '0;
        wait_q  <= '0;
        max_q   <= '0;
      end else if (bus.ack[i]) begin
        if (grant_q != '1) grant_q <= grant_q + stat_grant_t'(1);
        wait_q <= '0;
      end else if (bus.req[i] && (wait_q != '1)) begin
        wait_q <= wait_q + stat_wait_t'(1);
        if ((wait_q + stat_wait_t'(1)) > max_q) max_q <= wait_q + stat_wait_t'(1);
      end
    end

    assign stat_grant[i*StatGrantW +: StatGrantW]   = grant_q;
    assign stat_max_wait[i*StatWaitW +: StatWaitW] = max_q;
  end
`endif

endmodule
